// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver; optional even parity via UART_RX_PARITY_EN
module uart_rx #(
    parameter int CLK_HZ       = 12000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RX_data,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
`ifdef UART_RX_PARITY_EN
    ,
    output logic                    uart_rx_parity_err
`endif
);
    localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(PAYLOAD_BITS + 1);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_RX_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t                  state;
    logic [1:0]              sync;
    logic                    rx_prev;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [PAYLOAD_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                    par_bad;
`endif

    logic rx_s;
    assign rx_s = sync[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state             <= IDLE;
            sync              <= 2'b11;
            rx_prev           <= 1'b1;
            cnt               <= '0;
            idx               <= '0;
            shreg             <= '0;
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad            <= 1'b0;
            uart_rx_parity_err <= 1'b0;
`endif
        end else begin
            sync              <= {sync[0], RX_data};
            rx_prev           <= rx_s;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            uart_rx_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    // A low line left over from a bad stop bit cannot trigger: an edge needs a prior high
                    if (uart_rx_en && rx_prev && !rx_s)
                        state <= START;
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[PAYLOAD_BITS-1:1]};
                        if (idx == LAST_IDX) begin
                            idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        par_bad <= ^{shreg, rx_s};
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                uart_rx_parity_err <= 1'b1;
                            end else begin
                                uart_rx_data  <= shreg;
                                uart_rx_valid <= 1'b1;
                            end
`else
                            uart_rx_data  <= shreg;
                            uart_rx_valid <= 1'b1;
`endif
                        end else begin
                            uart_rx_frame_err <= 1'b1;
                            uart_rx_break     <= (shreg == '0);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
